simd_mac_unit: RTL and testbench



---
 rtl/simd_mac_unit_if.sv | 26 ++
 rtl/simd_mac_unit.sv | 160 ++++++++++++++++
 tb/tb_simd_mac_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_mac_unit_if.sv
// Request/response bundle between the core EXEC stage and the SIMD MAC.
// master issues requests and takes results; slave is the MAC itself.
interface simd_mac_unit_if #(
   parameter int XLEN = 32
);
   logic [1:0]      ctrl;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            valid_in;
   logic            ready_in;
   logic            valid_out;
   logic            ready_out;
   logic [XLEN-1:0] result;
   logic            busy;
   logic            acc_ovf;

   modport master (
      output ctrl, a, b, valid_in, ready_out,
      input  ready_in, valid_out, result, busy, acc_ovf
   );

   modport slave (
      input  ctrl, a, b, valid_in, ready_out,
      output ready_in, valid_out, result, busy, acc_ovf
   );
endinterface

// File: rtl/simd_mac_unit.sv
// Lane-serial SIMD multiply-accumulate unit with persistent accumulator.
// One shared multiplier walks the lanes; results leave via valid/ready.
module simd_mac_unit #(
   parameter int XLEN   = 32,
   parameter int LANE_W = 8
) (
   input logic            clk,
   input logic            rst,
   simd_mac_unit_if.slave bus
);
   localparam int LANES = XLEN / LANE_W;
   localparam int KW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PW    = (2 * LANE_W > XLEN) ? 2 * LANE_W : XLEN;

   localparam logic [1:0] OP_DOT    = 2'b00;
   localparam logic [1:0] OP_DOTACC = 2'b01;
   localparam logic [1:0] OP_VADDS  = 2'b10;
   localparam logic [1:0] OP_ACCRD  = 2'b11;

   if ((XLEN % LANE_W) != 0 ||
       !(LANE_W == 8 || LANE_W == 16 || LANE_W == 32)) begin : g_bad_cfg
      $error("simd_mac_unit: illegal XLEN/LANE_W combination");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN,
      DONE
   } state_e;

   state_e          state_q;
   logic [1:0]      ctrl_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [KW-1:0]   k_q;
   logic [XLEN-1:0] sum_q;
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] acc_q;
   logic            ovf_q;
   logic            rdy_q;
   logic            vld_q;
   logic            busy_q;

   logic signed [LANE_W-1:0]   la;
   logic signed [LANE_W-1:0]   lb;
   logic signed [2*LANE_W-1:0] prod;
   logic signed [PW-1:0]       prod_w;
   logic [XLEN-1:0]            sum_d;
   logic [LANE_W:0]            sadd;
   logic [LANE_W-1:0]          sat;
   logic [XLEN-1:0]            vres_d;
   logic [XLEN-1:0]            acc_d;
   logic                       ovf_d;

   always_comb begin
      la = '0;
      lb = '0;
      for (int i = 0; i < LANES; i++) begin
         if (k_q == KW'(i)) begin
            la = a_q[i*LANE_W +: LANE_W];
            lb = b_q[i*LANE_W +: LANE_W];
         end
      end
      // Full-width signed product; (-2^(n-1))^2 stays positive here
      prod   = (2*LANE_W)'(la) * (2*LANE_W)'(lb);
      prod_w = PW'(prod);
      sum_d  = sum_q + prod_w[XLEN-1:0];

      sadd = {la[LANE_W-1], la} + {lb[LANE_W-1], lb};
      sat  = sadd[LANE_W-1:0];
      if (sadd[LANE_W] != sadd[LANE_W-1]) begin
         sat = sadd[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                            : {1'b0, {(LANE_W-1){1'b1}}};
      end
      vres_d = res_q;
      for (int i = 0; i < LANES; i++) begin
         if (k_q == KW'(i)) vres_d[i*LANE_W +: LANE_W] = sat;
      end

      acc_d = acc_q + sum_q;
      ovf_d = (acc_q[XLEN-1] == sum_q[XLEN-1]) &&
              (acc_d[XLEN-1] != acc_q[XLEN-1]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         sum_q   <= '0;
         res_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.valid_in && rdy_q) begin
                  ctrl_q <= bus.ctrl;
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  busy_q <= 1'b1;
                  rdy_q  <= 1'b0;
                  if (bus.ctrl == OP_ACCRD) begin
                     res_q   <= acc_q;
                     acc_q   <= '0;
                     ovf_q   <= 1'b0;
                     vld_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     k_q     <= '0;
                     sum_q   <= '0;
                     res_q   <= '0;
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (ctrl_q == OP_VADDS) res_q <= vres_d;
               else                    sum_q <= sum_d;
               k_q <= k_q + 1'b1;
               if (k_q == KW'(LANES - 1)) state_q <= FIN;
            end
            FIN: begin
               unique case (ctrl_q)
                  OP_DOT: res_q <= sum_q;
                  OP_DOTACC: begin
                     acc_q <= acc_d;
                     res_q <= acc_d;
                     if (ovf_d) ovf_q <= 1'b1;
                  end
                  default: ;
               endcase
               vld_q   <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               if (bus.ready_out) begin
                  vld_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready_in  = rdy_q;
   assign bus.valid_out = vld_q;
   assign bus.result    = res_q;
   assign bus.busy      = busy_q;
   assign bus.acc_ovf   = ovf_q;
endmodule

// File: tb/tb_simd_mac_unit.sv
// Directed bench for simd_mac_unit: LANE_W=8 and LANE_W=16 instances.
// Latency counts clock edges from the accept edge (inclusive) to valid_out.
module tb_simd_mac_unit;
   localparam logic [1:0] DOT    = 2'b00;
   localparam logic [1:0] DOTACC = 2'b01;
   localparam logic [1:0] VADDS  = 2'b10;
   localparam logic [1:0] ACCRD  = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   simd_mac_unit_if #(.XLEN(32)) bus8 ();
   simd_mac_unit_if #(.XLEN(32)) bus16 ();

   simd_mac_unit #(.XLEN(32), .LANE_W(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   simd_mac_unit #(.XLEN(32), .LANE_W(16)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   function automatic logic f_rdy(input bit w);
      return w ? bus16.ready_in : bus8.ready_in;
   endfunction
   function automatic logic f_vld(input bit w);
      return w ? bus16.valid_out : bus8.valid_out;
   endfunction
   function automatic logic f_busy(input bit w);
      return w ? bus16.busy : bus8.busy;
   endfunction
   function automatic logic f_ovf(input bit w);
      return w ? bus16.acc_ovf : bus8.acc_ovf;
   endfunction
   function automatic logic [31:0] f_res(input bit w);
      return w ? bus16.result : bus8.result;
   endfunction

   task automatic drive(input bit w, input logic v, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ro);
      if (w) begin
         bus16.valid_in = v; bus16.ctrl = op;
         bus16.a = a; bus16.b = b; bus16.ready_out = ro;
      end else begin
         bus8.valid_in = v; bus8.ctrl = op;
         bus8.a = a; bus8.b = b; bus8.ready_out = ro;
      end
   endtask

   // One full transaction with ready_out held high.
   task automatic run_op(input bit w, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output bit busy_ok);
      @(negedge clk);
      drive(w, 1'b1, op, a, b, 1'b1);
      busy_ok = 1'b1;
      for (int n = 0; n < 20 && !f_rdy(w); n++) @(negedge clk);
      @(posedge clk);
      #1;
      drive(w, 1'b0, ~op, ~a, ~b, 1'b1);
      lat = 1;
      while (!f_vld(w) && lat < 40) begin
         if (!f_busy(w)) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (!f_busy(w)) busy_ok = 1'b0;
      res = f_res(w);
      @(posedge clk);
      #1;
      drive(w, 1'b0, DOT, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_reset;
      drive(1'b0, 1'b0, DOT, 32'h0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, DOT, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         n_chk++;
         if ({f_rdy(w[0]), f_vld(w[0]), f_busy(w[0]), f_ovf(w[0])} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags w%0d: got %b want 1000", w,
                     {f_rdy(w[0]), f_vld(w[0]), f_busy(w[0]), f_ovf(w[0])});
         end
         n_chk++;
         if (f_res(w[0]) !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result w%0d: got %h want 0", w, f_res(w[0]));
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_dot_basic;
      logic [31:0] r;
      int lat;
      bit bok;
      run_op(1'b0, DOT, 32'h01020304, 32'h01010101, r, lat, bok);
      n_chk++;
      if (r !== 32'h0000000A) begin
         n_fail++;
         $display("FAIL dot_basic: got %h want 0000000a", r);
      end
      n_chk++;
      if (lat !== 6) begin
         n_fail++;
         $display("FAIL dot_latency: got %0d want 6", lat);
      end
      n_chk++;
      if (bok !== 1'b1) begin
         n_fail++;
         $display("FAIL dot_busy: busy dropped before result");
      end
      n_chk++;
      if ({f_vld(0), f_busy(0), f_rdy(0)} !== 3'b001) begin
         n_fail++;
         $display("FAIL post_handshake: got %b want 001",
                  {f_vld(0), f_busy(0), f_rdy(0)});
      end
   endtask

   task automatic test_dot_patterns;
      logic [31:0] r;
      int lat;
      bit bok;
      run_op(1'b0, DOT, 32'hFFFFFFFF, 32'h02020202, r, lat, bok);
      n_chk++;
      if (r !== 32'hFFFFFFF8) begin
         n_fail++;
         $display("FAIL dot_neg: got %h want fffffff8", r);
      end
      run_op(1'b0, DOT, 32'h80808080, 32'h80808080, r, lat, bok);
      n_chk++;
      if (r !== 32'h00010000) begin
         n_fail++;
         $display("FAIL dot_minsq: got %h want 00010000", r);
      end
   endtask

   task automatic test_dotacc;
      logic [31:0] r;
      int lat;
      bit bok;
      run_op(1'b0, DOTACC, 32'h7F7F7F7F, 32'h7F7F7F7F, r, lat, bok);
      n_chk++;
      if (r !== 32'h0000FC04) begin
         n_fail++;
         $display("FAIL dotacc_1: got %h want 0000fc04", r);
      end
      run_op(1'b0, DOTACC, 32'h7F7F7F7F, 32'h7F7F7F7F, r, lat, bok);
      n_chk++;
      if (r !== 32'h0001F808) begin
         n_fail++;
         $display("FAIL dotacc_2: got %h want 0001f808", r);
      end
      run_op(1'b0, ACCRD, 32'h0, 32'h0, r, lat, bok);
      n_chk++;
      if (r !== 32'h0001F808) begin
         n_fail++;
         $display("FAIL accrd_1: got %h want 0001f808", r);
      end
      n_chk++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL accrd_latency: got %0d want 1", lat);
      end
      run_op(1'b0, ACCRD, 32'h0, 32'h0, r, lat, bok);
      n_chk++;
      if (r !== 32'h0 || f_ovf(0) !== 1'b0) begin
         n_fail++;
         $display("FAIL accrd_2: got %h ovf %b want 0 ovf 0", r, f_ovf(0));
      end
   endtask

   task automatic test_vadds;
      logic [31:0] r;
      int lat;
      bit bok;
      run_op(1'b0, VADDS, 32'h7F8010F0, 32'h01FF05F0, r, lat, bok);
      n_chk++;
      if (r !== 32'h7F8015E0) begin
         n_fail++;
         $display("FAIL vadds_sat: got %h want 7f8015e0", r);
      end
      n_chk++;
      if (lat !== 6) begin
         n_fail++;
         $display("FAIL vadds_latency: got %0d want 6", lat);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] r;
      int lat;
      int n;
      bit bok;
      @(negedge clk);
      drive(1'b0, 1'b1, DOTACC, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, DOT, 32'h0, 32'h0, 1'b0);
      n = 0;
      while (!f_vld(0) && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_chk++;
      if (f_vld(0) !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_valid_timeout: valid_out %b want 1", f_vld(0));
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1'b0, i == 4, ACCRD, 32'h0, 32'h0, 1'b0);
         @(posedge clk);
         #1;
         n_chk++;
         if ({f_vld(0), f_rdy(0), f_busy(0)} !== 3'b101 ||
             f_res(0) !== 32'h0000FC04) begin
            n_fail++;
            $display("FAIL bp_hold c%0d: v/r/b %b res %h want 101 0000fc04",
                     i, {f_vld(0), f_rdy(0), f_busy(0)}, f_res(0));
         end
      end
      @(negedge clk);
      drive(1'b0, 1'b0, DOT, 32'h0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, DOT, 32'h0, 32'h0, 1'b0);
      n_chk++;
      if ({f_vld(0), f_busy(0), f_rdy(0)} !== 3'b001) begin
         n_fail++;
         $display("FAIL bp_release: got %b want 001",
                  {f_vld(0), f_busy(0), f_rdy(0)});
      end
      run_op(1'b0, ACCRD, 32'h0, 32'h0, r, lat, bok);
      n_chk++;
      if (r !== 32'h0000FC04) begin
         n_fail++;
         $display("FAIL bp_ignored_req: got %h want 0000fc04", r);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r1;
      logic [31:0] r2;
      int lat;
      bit bok;
      run_op(1'b0, DOT, 32'h05FB0203, 32'h03030404, r1, lat, bok);
      run_op(1'b0, VADDS, 32'h01020304, 32'h10203040, r2, lat, bok);
      n_chk++;
      if (r1 !== 32'h00000014 || r2 !== 32'h11223344) begin
         n_fail++;
         $display("FAIL back_to_back: got %h %h want 00000014 11223344",
                  r1, r2);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] r;
      int lat;
      bit bok;
      run_op(1'b0, DOTACC, 32'h7F7F7F7F, 32'h7F7F7F7F, r, lat, bok);
      @(negedge clk);
      drive(1'b0, 1'b1, DOTACC, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, DOT, 32'h0, 32'h0, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_chk++;
      if ({f_vld(0), f_busy(0), f_rdy(0)} !== 3'b001 || f_res(0) !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid: v/b/r %b res %h want 001 0",
                  {f_vld(0), f_busy(0), f_rdy(0)}, f_res(0));
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_chk++;
      if ({f_vld(0), f_rdy(0)} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_release: v/r %b want 01", {f_vld(0), f_rdy(0)});
      end
      run_op(1'b0, ACCRD, 32'h0, 32'h0, r, lat, bok);
      n_chk++;
      if (r !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_acc_lost: got %h want 0", r);
      end
   endtask

   task automatic test_lane16;
      logic [31:0] r;
      int lat;
      bit bok;
      run_op(1'b1, DOT, 32'h01020304, 32'h01010101, r, lat, bok);
      n_chk++;
      if (r !== 32'h00040A06) begin
         n_fail++;
         $display("FAIL w16_dot: got %h want 00040a06", r);
      end
      n_chk++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL w16_latency: got %0d want 4", lat);
      end
   endtask

   task automatic test_overflow;
      logic [31:0] r;
      int lat;
      bit bok;
      run_op(1'b1, DOTACC, 32'h7FFF7FFF, 32'h7FFF7FFF, r, lat, bok);
      n_chk++;
      if (r !== 32'h7FFE0002 || f_ovf(1) !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_step1: got %h ovf %b want 7ffe0002 ovf 0",
                  r, f_ovf(1));
      end
      run_op(1'b1, DOTACC, 32'h7FFF7FFF, 32'h7FFF7FFF, r, lat, bok);
      n_chk++;
      if (r !== 32'hFFFC0004 || f_ovf(1) !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_step2: got %h ovf %b want fffc0004 ovf 1",
                  r, f_ovf(1));
      end
      run_op(1'b1, DOT, 32'h00010001, 32'h00010001, r, lat, bok);
      n_chk++;
      if (r !== 32'h00000002 || f_ovf(1) !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky_dot: got %h ovf %b want 00000002 ovf 1",
                  r, f_ovf(1));
      end
      run_op(1'b1, VADDS, 32'h7FFF8000, 32'h00010001, r, lat, bok);
      n_chk++;
      if (r !== 32'h7FFF8001 || f_ovf(1) !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky_vadds: got %h ovf %b want 7fff8001 ovf 1",
                  r, f_ovf(1));
      end
      run_op(1'b1, ACCRD, 32'h0, 32'h0, r, lat, bok);
      n_chk++;
      if (r !== 32'hFFFC0004 || f_ovf(1) !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %h ovf %b want fffc0004 ovf 0",
                  r, f_ovf(1));
      end
   endtask

   initial begin
      test_reset();
      test_dot_basic();
      test_dot_patterns();
      test_dotacc();
      test_vadds();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_lane16();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
